// File: rtl/clk_div_prog.sv
// Programmable clock divider with 50% duty for even and odd ratios.
// Divisor changes are queued in a pending register and applied only on a period boundary.
module clk_div_prog #(
    parameter int CNT_W   = 8,
    parameter int DIV_RST = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             div_vld_i,
    input  logic [CNT_W-1:0] div_i,
    output logic             out,
    output logic             tick_o,
    output logic             pend_o,
    output logic             err_o,
    output logic [CNT_W-1:0] div_act_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);
    localparam logic [CNT_W-1:0] DIV_RST_V = CNT_W'(DIV_RST);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] div_act_reg, div_act_next;
    logic [CNT_W-1:0] pend_div_reg, pend_div_next;
    logic             pend_reg, pend_next;
    logic             err_reg, err_next;
    logic             pos_reg, pos_next;
    logic             neg_reg;
    logic [CNT_W-1:0] last_cur;
    logic [CNT_W-1:0] half_next;
    logic             at_last;
    logic             wr_ok;
    logic             wr_bad;
    logic             apply;

    always_comb begin
        last_cur      = div_act_reg - ONE;
        at_last       = (state_reg == RUN) && (cnt_reg == last_cur);
        wr_ok         = div_vld_i && (div_i >= TWO);
        wr_bad        = div_vld_i && (div_i < TWO);
        // IDLE has no period in flight, so a pending divisor can be taken immediately.
        apply         = pend_reg && ((state_reg == IDLE) || at_last);

        state_next    = state_reg;
        case (state_reg)
            IDLE:    if (en_i) state_next = RUN;
            RUN:     if (at_last && !en_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        cnt_next      = ((state_reg == RUN) && !at_last) ? cnt_reg + ONE : '0;
        div_act_next  = apply ? pend_div_reg : div_act_reg;
        pend_div_next = wr_ok ? div_i : pend_div_reg;
        pend_next     = wr_ok || (pend_reg && !apply);
        err_next      = wr_bad;

        // High phase is evaluated against the divisor that will be active next cycle,
        // so the first cycle after a switch already follows the new ratio.
        half_next     = div_act_next >> 1;
        pos_next      = (state_next == RUN) && (cnt_next < half_next);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            div_act_reg  <= DIV_RST_V;
            pend_div_reg <= DIV_RST_V;
            pend_reg     <= 1'b0;
            err_reg      <= 1'b0;
            pos_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            div_act_reg  <= div_act_next;
            pend_div_reg <= pend_div_next;
            pend_reg     <= pend_next;
            err_reg      <= err_next;
            pos_reg      <= pos_next;
        end
    end

    // Half-cycle stretch for odd ratios; it is always low at a period boundary,
    // so switching between even and odd selection cannot glitch.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            neg_reg <= 1'b0;
        end else begin
            neg_reg <= pos_reg;
        end
    end

    assign out       = div_act_reg[0] ? (pos_reg | neg_reg) : pos_reg;
    assign tick_o    = at_last;
    assign pend_o    = pend_reg;
    assign err_o     = err_reg;
    assign div_act_o = div_act_reg;

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: per-cycle stimulus and expected outputs are queued
// together, then each scenario drives the queue and compares both half-cycles of out.
module tb_clk_div_prog;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_i;
    logic       div_vld_i;
    logic [7:0] div_i;
    logic       out;
    logic       tick_o;
    logic       pend_o;
    logic       err_o;
    logic [7:0] div_act_o;

    clk_div_prog #(
        .CNT_W  (8),
        .DIV_RST(5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en_i     (en_i),
        .div_vld_i(div_vld_i),
        .div_i    (div_i),
        .out      (out),
        .tick_o   (tick_o),
        .pend_o   (pend_o),
        .err_o    (err_o),
        .div_act_o(div_act_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       en;
        logic       vld;
        logic [7:0] div;
    } stim_t;

    typedef struct packed {
        logic       out_p;
        logic       out_n;
        logic       tick;
        logic       pend;
        logic       err;
        logic [7:0] act;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    logic       s_out_p, s_out_n, s_tick, s_pend, s_err;
    logic [7:0] s_act;

    // One clk cycle: sample just after the posedge, and out again just after the negedge.
    task automatic cyc();
        @(posedge clk);
        #2;
        s_out_p = out;
        s_tick  = tick_o;
        s_pend  = pend_o;
        s_err   = err_o;
        s_act   = div_act_o;
        @(negedge clk);
        #2;
        s_out_n = out;
    endtask

    task automatic push_stim(input logic en, input logic vld, input logic [7:0] div);
        stim_t s;
        s.en  = en;
        s.vld = vld;
        s.div = div;
        stim_q.push_back(s);
    endtask

    // Cycle k of an N period: out is high for the first N half-cycles, tick in the last cycle.
    task automatic plan_run(input logic en, input logic vld, input logic [7:0] div, input int n,
                            input int k, input logic pend, input logic err, input logic [7:0] act);
        exp_t e;
        push_stim(en, vld, div);
        e.out_p = (2 * k < n);
        e.out_n = (2 * k + 1 < n);
        e.tick  = (k == n - 1);
        e.pend  = pend;
        e.err   = err;
        e.act   = act;
        exp_q.push_back(e);
    endtask

    task automatic plan_idle(input logic en, input logic vld, input logic [7:0] div,
                             input logic pend, input logic err, input logic [7:0] act);
        exp_t e;
        push_stim(en, vld, div);
        e.out_p = 1'b0;
        e.out_n = 1'b0;
        e.tick  = 1'b0;
        e.pend  = pend;
        e.err   = err;
        e.act   = act;
        exp_q.push_back(e);
    endtask

    task automatic plan_period(input int n, input logic [7:0] act);
        for (int k = 0; k < n; k++) plan_run(1'b1, 1'b0, 8'd0, n, k, 1'b0, 1'b0, act);
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        en_i      = 1'b0;
        div_vld_i = 1'b0;
        div_i     = 8'd0;
        @(negedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        exp_t  e;
        stim_t s;
        int    cyc_n;
        rst       = 1'b0;
        en_i      = 1'b1;
        div_vld_i = 1'b1;
        div_i     = 8'd9;
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if ({out, tick_o, pend_o, err_o, div_act_o} !== {4'b0000, 8'd5}) begin
            n_fail++;
            $display("FAIL reset_hold: got out/tick/pend/err/act=%b%b%b%b/%0d required 0000/5",
                     out, tick_o, pend_o, err_o, div_act_o);
        end
        en_i      = 1'b0;
        div_vld_i = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        plan_idle(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd5);
        plan_idle(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd5);
        cyc_n = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            en_i = s.en; div_vld_i = s.vld; div_i = s.div;
            cyc();
            e = exp_q.pop_front();
            n_tests++;
            if ({s_out_p, s_out_n, s_tick, s_pend, s_err, s_act} !== e) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: got outp,outn,tick,pend,err,act=%b required %b",
                         cyc_n, {s_out_p, s_out_n, s_tick, s_pend, s_err, s_act}, e);
            end
            $display("[TB] reset_idle cycle %0d out=%b%b act=%0d", cyc_n, s_out_p, s_out_n, s_act);
            cyc_n++;
        end
    endtask

    task automatic test_default();
        exp_t  e;
        stim_t s;
        int    cyc_n;
        do_reset();
        repeat (3) plan_period(5, 8'd5);
        cyc_n = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            en_i = s.en; div_vld_i = s.vld; div_i = s.div;
            cyc();
            e = exp_q.pop_front();
            n_tests++;
            if ({s_out_p, s_out_n, s_tick, s_pend, s_err, s_act} !== e) begin
                n_fail++;
                $display("FAIL default cycle %0d: got outp,outn,tick,pend,err,act=%b required %b",
                         cyc_n, {s_out_p, s_out_n, s_tick, s_pend, s_err, s_act}, e);
            end
            $display("[TB] default cycle %0d out=%b%b tick=%b", cyc_n, s_out_p, s_out_n, s_tick);
            cyc_n++;
        end
    endtask

    task automatic test_even();
        exp_t  e;
        stim_t s;
        int    cyc_n;
        do_reset();
        plan_idle(1'b0, 1'b1, 8'd4, 1'b1, 1'b0, 8'd5);
        plan_idle(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd4);
        repeat (2) plan_period(4, 8'd4);
        cyc_n = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            en_i = s.en; div_vld_i = s.vld; div_i = s.div;
            cyc();
            e = exp_q.pop_front();
            n_tests++;
            if ({s_out_p, s_out_n, s_tick, s_pend, s_err, s_act} !== e) begin
                n_fail++;
                $display("FAIL even cycle %0d: got outp,outn,tick,pend,err,act=%b required %b",
                         cyc_n, {s_out_p, s_out_n, s_tick, s_pend, s_err, s_act}, e);
            end
            $display("[TB] even cycle %0d out=%b%b act=%0d", cyc_n, s_out_p, s_out_n, s_act);
            cyc_n++;
        end
    endtask

    task automatic test_odd_change();
        exp_t  e;
        stim_t s;
        int    cyc_n;
        do_reset();
        plan_idle(1'b0, 1'b1, 8'd4, 1'b1, 1'b0, 8'd5);
        plan_run(1'b1, 1'b0, 8'd0, 4, 0, 1'b0, 1'b0, 8'd4);
        plan_run(1'b1, 1'b0, 8'd0, 4, 1, 1'b0, 1'b0, 8'd4);
        plan_run(1'b1, 1'b1, 8'd7, 4, 2, 1'b1, 1'b0, 8'd4);
        plan_run(1'b1, 1'b0, 8'd0, 4, 3, 1'b1, 1'b0, 8'd4);
        repeat (2) plan_period(7, 8'd7);
        cyc_n = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            en_i = s.en; div_vld_i = s.vld; div_i = s.div;
            cyc();
            e = exp_q.pop_front();
            n_tests++;
            if ({s_out_p, s_out_n, s_tick, s_pend, s_err, s_act} !== e) begin
                n_fail++;
                $display("FAIL odd_change cycle %0d: got outp,outn,tick,pend,err,act=%b required %b",
                         cyc_n, {s_out_p, s_out_n, s_tick, s_pend, s_err, s_act}, e);
            end
            $display("[TB] odd_change cycle %0d out=%b%b pend=%b act=%0d",
                     cyc_n, s_out_p, s_out_n, s_pend, s_act);
            cyc_n++;
        end
    endtask

    task automatic test_illegal();
        exp_t  e;
        stim_t s;
        int    cyc_n;
        do_reset();
        plan_run(1'b1, 1'b0, 8'd0, 5, 0, 1'b0, 1'b0, 8'd5);
        plan_run(1'b1, 1'b1, 8'd1, 5, 1, 1'b0, 1'b1, 8'd5);
        plan_run(1'b1, 1'b1, 8'd0, 5, 2, 1'b0, 1'b1, 8'd5);
        plan_run(1'b1, 1'b1, 8'd3, 5, 3, 1'b1, 1'b0, 8'd5);
        plan_run(1'b1, 1'b1, 8'd1, 5, 4, 1'b1, 1'b1, 8'd5);
        repeat (2) plan_period(3, 8'd3);
        cyc_n = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            en_i = s.en; div_vld_i = s.vld; div_i = s.div;
            cyc();
            e = exp_q.pop_front();
            n_tests++;
            if ({s_out_p, s_out_n, s_tick, s_pend, s_err, s_act} !== e) begin
                n_fail++;
                $display("FAIL illegal cycle %0d: got outp,outn,tick,pend,err,act=%b required %b",
                         cyc_n, {s_out_p, s_out_n, s_tick, s_pend, s_err, s_act}, e);
            end
            $display("[TB] illegal cycle %0d err=%b pend=%b act=%0d", cyc_n, s_err, s_pend, s_act);
            cyc_n++;
        end
    endtask

    task automatic test_en_drop();
        exp_t  e;
        stim_t s;
        int    cyc_n;
        do_reset();
        plan_idle(1'b0, 1'b1, 8'd6, 1'b1, 1'b0, 8'd5);
        plan_run(1'b1, 1'b0, 8'd0, 6, 0, 1'b0, 1'b0, 8'd6);
        plan_run(1'b1, 1'b0, 8'd0, 6, 1, 1'b0, 1'b0, 8'd6);
        for (int k = 2; k < 6; k++) plan_run(1'b0, 1'b0, 8'd0, 6, k, 1'b0, 1'b0, 8'd6);
        repeat (3) plan_idle(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd6);
        cyc_n = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            en_i = s.en; div_vld_i = s.vld; div_i = s.div;
            cyc();
            e = exp_q.pop_front();
            n_tests++;
            if ({s_out_p, s_out_n, s_tick, s_pend, s_err, s_act} !== e) begin
                n_fail++;
                $display("FAIL en_drop cycle %0d: got outp,outn,tick,pend,err,act=%b required %b",
                         cyc_n, {s_out_p, s_out_n, s_tick, s_pend, s_err, s_act}, e);
            end
            $display("[TB] en_drop cycle %0d out=%b%b tick=%b", cyc_n, s_out_p, s_out_n, s_tick);
            cyc_n++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t  e;
        stim_t s;
        int    cyc_n;
        do_reset();
        plan_run(1'b1, 1'b0, 8'd0, 5, 0, 1'b0, 1'b0, 8'd5);
        plan_run(1'b1, 1'b1, 8'd2, 5, 1, 1'b1, 1'b0, 8'd5);
        for (int k = 2; k < 5; k++) plan_run(1'b1, 1'b0, 8'd0, 5, k, 1'b1, 1'b0, 8'd5);
        // write on the apply edge: 2 goes active, 4 stays pending
        plan_run(1'b1, 1'b1, 8'd4, 2, 0, 1'b1, 1'b0, 8'd2);
        plan_run(1'b1, 1'b0, 8'd0, 2, 1, 1'b1, 1'b0, 8'd2);
        plan_run(1'b1, 1'b0, 8'd0, 4, 0, 1'b0, 1'b0, 8'd4);
        plan_run(1'b1, 1'b1, 8'd6, 4, 1, 1'b1, 1'b0, 8'd4);
        plan_run(1'b1, 1'b1, 8'd3, 4, 2, 1'b1, 1'b0, 8'd4);
        plan_run(1'b1, 1'b0, 8'd0, 4, 3, 1'b1, 1'b0, 8'd4);
        plan_period(3, 8'd3);
        cyc_n = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            en_i = s.en; div_vld_i = s.vld; div_i = s.div;
            cyc();
            e = exp_q.pop_front();
            n_tests++;
            if ({s_out_p, s_out_n, s_tick, s_pend, s_err, s_act} !== e) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: got outp,outn,tick,pend,err,act=%b required %b",
                         cyc_n, {s_out_p, s_out_n, s_tick, s_pend, s_err, s_act}, e);
            end
            $display("[TB] back_to_back cycle %0d pend=%b act=%0d", cyc_n, s_pend, s_act);
            cyc_n++;
        end
    endtask

    task automatic test_async_reset();
        exp_t  e;
        stim_t s;
        int    cyc_n;
        do_reset();
        plan_idle(1'b0, 1'b1, 8'd7, 1'b1, 1'b0, 8'd5);
        plan_run(1'b1, 1'b0, 8'd0, 7, 0, 1'b0, 1'b0, 8'd7);
        cyc_n = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            en_i = s.en; div_vld_i = s.vld; div_i = s.div;
            cyc();
            e = exp_q.pop_front();
            n_tests++;
            if ({s_out_p, s_out_n, s_tick, s_pend, s_err, s_act} !== e) begin
                n_fail++;
                $display("FAIL async_pre cycle %0d: got outp,outn,tick,pend,err,act=%b required %b",
                         cyc_n, {s_out_p, s_out_n, s_tick, s_pend, s_err, s_act}, e);
            end
            $display("[TB] async_pre cycle %0d out=%b%b", cyc_n, s_out_p, s_out_n);
            cyc_n++;
        end
        // clk is low here and out is high; reset must act before the next edge
        rst  = 1'b0;
        en_i = 1'b0;
        #1;
        n_tests++;
        if ({out, tick_o, pend_o, err_o, div_act_o} !== {4'b0000, 8'd5}) begin
            n_fail++;
            $display("FAIL async_reset: got out/tick/pend/err/act=%b%b%b%b/%0d required 0000/5",
                     out, tick_o, pend_o, err_o, div_act_o);
        end
        $display("[TB] async_reset out=%b act=%0d", out, div_act_o);
        @(negedge clk);
        #2;
        rst = 1'b1;
        repeat (2) plan_idle(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd5);
        plan_period(5, 8'd5);
        cyc_n = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            en_i = s.en; div_vld_i = s.vld; div_i = s.div;
            cyc();
            e = exp_q.pop_front();
            n_tests++;
            if ({s_out_p, s_out_n, s_tick, s_pend, s_err, s_act} !== e) begin
                n_fail++;
                $display("FAIL async_post cycle %0d: got outp,outn,tick,pend,err,act=%b required %b",
                         cyc_n, {s_out_p, s_out_n, s_tick, s_pend, s_err, s_act}, e);
            end
            $display("[TB] async_post cycle %0d out=%b%b", cyc_n, s_out_p, s_out_n);
            cyc_n++;
        end
    endtask

    initial begin
        rst       = 1'b0;
        en_i      = 1'b0;
        div_vld_i = 1'b0;
        div_i     = 8'd0;
        test_reset();
        test_default();
        test_even();
        test_odd_change();
        test_illegal();
        test_en_drop();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
